// File: rtl/pwm_output_stage.sv
// pwm_output_stage: prescaled 8-bit PWM driving 16 enable/mode-gated pins.
// Optional PWM_PERIOD_PULSE_EN adds a one-clk period_tick after each wrap.
module pwm_output_stage #(
  parameter int unsigned CLK_DIV    = 13,
  parameter int unsigned PERIOD_MAX = 254
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out_pins
`ifdef PWM_PERIOD_PULSE_EN
  ,
  output logic        period_tick
`endif
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_LAST = 8'(PERIOD_MAX);

  logic [15:0] prescaler_q;
  logic [15:0] prescaler_d;
  logic [7:0]  pwm_count_q;
  logic [7:0]  pwm_count_d;
  logic [7:0]  duty_shadow_q;
  logic [7:0]  duty_shadow_d;
  logic        first_q;
  logic        first_d;
  logic [15:0] out_pins_q;
  logic [15:0] out_pins_d;

  logic        tick;
  logic        wrap;
  logic        pwm_lvl;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  // Prescaler: one tick per CLK_DIV system clocks.
  always_comb begin
    tick        = (prescaler_q == DIV_LAST);
    prescaler_d = tick ? 16'd0 : prescaler_q + 16'd1;
  end

  // Period counter advances on tick and wraps after CNT_LAST.
  always_comb begin
    wrap        = tick && (pwm_count_q >= CNT_LAST);
    pwm_count_d = pwm_count_q;
    if (tick) begin
      pwm_count_d = wrap ? 8'd0 : pwm_count_q + 8'd1;
    end
  end

  // Shadow duty only reloads at period start or right after reset.
  always_comb begin
    duty_shadow_d = duty_shadow_q;
    if (wrap || first_q) begin
      duty_shadow_d = pwm_duty_cycle;
    end
    first_d = 1'b0;
  end

  // Shared PWM level derived from the shadowed duty.
  always_comb begin
    pwm_lvl = 1'b0;
    unique case (1'b1)
      (duty_shadow_q == 8'hFF): pwm_lvl = 1'b1;
      (duty_shadow_q == 8'h00): pwm_lvl = 1'b0;
      default:                  pwm_lvl = (pwm_count_q < duty_shadow_q);
    endcase
  end

  // Per-pin select: off, static high, or PWM.
  always_comb begin
    en_out     = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    out_pins_d = en_out & (~en_pwm | {16{pwm_lvl}});
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q   <= 16'd0;
      pwm_count_q   <= 8'd0;
      duty_shadow_q <= 8'd0;
      first_q       <= 1'b1;
      out_pins_q    <= 16'd0;
    end else begin
      prescaler_q   <= prescaler_d;
      pwm_count_q   <= pwm_count_d;
      duty_shadow_q <= duty_shadow_d;
      first_q       <= first_d;
      out_pins_q    <= out_pins_d;
    end
  end

  assign out_pins = out_pins_q;

`ifdef PWM_PERIOD_PULSE_EN
  logic period_tick_q;
  logic period_tick_d;

  // Pulse lands on the clk where the counter returns to zero.
  always_comb begin
    period_tick_d = wrap;
  end

  // Registered period pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_tick_q <= 1'b0;
    end else begin
      period_tick_q <= period_tick_d;
    end
  end

  assign period_tick = period_tick_q;
`endif

endmodule

// File: tb/tb_pwm_output_stage.sv
// tb_pwm_output_stage: directed checks of pwm_output_stage.
// CLK_DIV=4 main instance; CLK_DIV=2 instance for the period pulse.
module tb_pwm_output_stage;

  localparam int PER = 1020;

  logic        clk;
  logic        rst;
  logic [7:0]  eo_lo;
  logic [7:0]  eo_hi;
  logic [7:0]  ep_lo;
  logic [7:0]  ep_hi;
  logic [7:0]  duty;
  logic [15:0] out_pins;
`ifdef PWM_PERIOD_PULSE_EN
  logic        pt1;
  logic        pt2;
  logic [15:0] out2;
`endif

  int total;
  int bad;
  int cyc;
  int hi;
  int mix;
  int fall;
  bit started;
  int pulse_err;

  pwm_output_stage #(.CLK_DIV(4), .PERIOD_MAX(254)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out_pins        (out_pins)
`ifdef PWM_PERIOD_PULSE_EN
    ,
    .period_tick     (pt1)
`endif
  );

`ifdef PWM_PERIOD_PULSE_EN
  pwm_output_stage #(.CLK_DIV(2), .PERIOD_MAX(254)) dut2 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out_pins        (out2),
    .period_tick     (pt2)
  );

  always @(negedge clk) begin
    if (started) begin
      if (pt2 !== ((cyc != 0) && (cyc % 510 == 0))) pulse_err++;
    end
  end
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc++;
    #1;
  endtask

  task automatic goto_wrap();
    do step(); while (cyc % PER != 0);
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    eo_lo = eo[7:0];
    eo_hi = eo[15:8];
    ep_lo = ep[7:0];
    ep_hi = ep[15:8];
  endtask

  task automatic run_per(input int np, input int mid_j,
                         input logic [7:0] mid_d,
                         output int h, output int m, output int f);
    bit was_hi;
    h = 0;
    m = 0;
    f = 0;
    was_hi = 1'b0;
    for (int k = 1; k <= np * PER; k++) begin
      step();
      if (out_pins == 16'hFFFF) begin
        h++;
        was_hi = 1'b1;
      end else if (out_pins != 16'h0000) begin
        m++;
      end else if (was_hi && f == 0) begin
        f = k;
      end
      if (k == mid_j) duty = mid_d;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    pulse_err = 0;
    started = 1'b0;
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      step();
      started = 1'b1;
      chk("rst_out", 32'(out_pins), 32'h0);
    end
    rst = 1'b0;
    step();
    chk("rel_out", 32'(out_pins), 32'h0);
    chk("rel_cnt", 32'(dut.pwm_count_q), 32'h0);
    chk("rel_shadow", 32'(dut.duty_shadow_q), 32'hFF);
    step();
    chk("rel_out2", 32'(out_pins), 32'hFFFF);

    set_en(16'hA5C3, 16'h0000);
    step();
    chk("static_on", 32'(out_pins), 32'hA5C3);
    set_en(16'h0000, 16'h0000);
    step();
    chk("static_off", 32'(out_pins), 32'h0);

    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h00;
    goto_wrap();
    run_per(2, 0, 8'h00, hi, mix, fall);
    chk("d00_hi", 32'(hi), 32'd0);
    chk("d00_mix", 32'(mix), 32'd0);

    duty = 8'hFF;
    goto_wrap();
    run_per(2, 0, 8'hFF, hi, mix, fall);
    chk("dff_hi", 32'(hi), 32'd2040);
    chk("dff_mix", 32'(mix), 32'd0);

    duty = 8'h40;
    goto_wrap();
    run_per(2, 0, 8'h40, hi, mix, fall);
    chk("d40_hi", 32'(hi), 32'd512);
    chk("d40_mix", 32'(mix), 32'd0);
    chk("d40_fall", 32'(fall), 32'd257);

    duty = 8'h20;
    goto_wrap();
    run_per(1, 401, 8'hC0, hi, mix, fall);
    chk("sh_cur_hi", 32'(hi), 32'd128);
    chk("sh_cur_fall", 32'(fall), 32'd129);
    chk("sh_cur_mix", 32'(mix), 32'd0);
    run_per(1, 0, 8'hC0, hi, mix, fall);
    chk("sh_nxt_hi", 32'(hi), 32'd768);
    chk("sh_nxt_fall", 32'(fall), 32'd769);

    set_en(16'hFFFF, 16'h00FF);
    do step(); while (cyc % PER != 900);
    chk("mixsel_lo", 32'(out_pins), 32'hFF00);
    set_en(16'hFFFF, 16'hFFFF);
    do step(); while (cyc % PER != 100);
    chk("resume_hi", 32'(out_pins), 32'hFFFF);

    do step(); while (cyc % PER != 500);
    rst = 1'b1;
    step();
    chk("mid_rst_out", 32'(out_pins), 32'h0);
    chk("mid_rst_cnt", 32'(dut.pwm_count_q), 32'h0);
    chk("mid_rst_psc", 32'(dut.prescaler_q), 32'h0);
    rst = 1'b0;

`ifdef PWM_PERIOD_PULSE_EN
    do step(); while (cyc != 509);
    chk("pt_509", 32'(pt2), 32'h0);
    step();
    chk("pt_510", 32'(pt2), 32'h1);
    step();
    chk("pt_511", 32'(pt2), 32'h0);
    do step(); while (cyc != 1020);
    chk("pt_1020", 32'(pt2), 32'h1);
    chk("pt1_1020", 32'(pt1), 32'h1);
    step();
    chk("pt1_1021", 32'(pt1), 32'h0);
    chk("pt_mon", 32'(pulse_err), 32'h0);
`else
    do step(); while (cyc != 8);
    chk("post_rst_cnt", 32'(dut.pwm_count_q), 32'h2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Downstream consumer of the SPI register bank (en_reg_out_*, en_reg_pwm_*, pwm_duty_cycle).
- Drives 16 output pins. Each pin is either forced low, statically high, or modulated by one shared 8-bit PWM waveform.
- Contains a clock prescaler, a period counter, a glitch-free shadowed duty register and registered output drivers.

Parameters:
- CLK_DIV, 13, system clocks per PWM count tick; legal range 1..65535.
- PERIOD_MAX, 254, last counter value before wrap (period = PERIOD_MAX+1 ticks); legal range 1..254.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- en_reg_out_7_0  input  8  output enable, pins 7..0.
- en_reg_out_15_8  input  8  output enable, pins 15..8.
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0.
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8.
- pwm_duty_cycle  input  8  requested duty; 0x00 = 0%, 0xFF = 100%.
- out_pins  output  16  registered pin drive; bit i = pin i.
- period_tick  output  1  present only with PWM_PERIOD_PULSE_EN; see Optional Feature.

Behaviour:
- Reset (rst=1 at posedge clk):
  - out_pins=0, prescaler=0, pwm_count=0, duty_shadow=0, period_tick=0.
  - Reset takes priority over every other event, including mid-period.
- Prescaler:
  - 16-bit counter, counts 0..CLK_DIV-1 then wraps.
  - tick=1 for exactly one clk when prescaler==CLK_DIV-1.
  - CLK_DIV=1: tick every clk.
- Period counter pwm_count (8-bit):
  - Advances only on tick.
  - pwm_count==PERIOD_MAX with tick -> 0. Otherwise +1.
  - Never exceeds PERIOD_MAX.
- Duty shadow:
  - duty_shadow <= pwm_duty_cycle only on the wrap tick (pwm_count==PERIOD_MAX and tick), and on the first clk after reset deassertion.
  - Mid-period duty writes never alter the current period.
- PWM level (combinational, from shadow):
  - duty_shadow==0xFF -> 1.
  - duty_shadow==0x00 -> 0.
  - Else (pwm_count < duty_shadow).
  - Duty values above PERIOD_MAX (other than 0xFF) yield constant high.
- Per-pin select, for pin i with en_out=concat of out regs and en_pwm=concat of pwm regs:
  - en_out[i]=0 -> 0.
  - en_out[i]=1, en_pwm[i]=0 -> 1.
  - en_out[i]=1, en_pwm[i]=1 -> PWM level.
- Latency:
  - out_pins registered; enable/mode changes visible one clk after the input change, with no period alignment.
  - PWM edges appear one clk after the tick that moves pwm_count.
- High time per period = duty_shadow ticks × CLK_DIV clks.
  - Example: CLK_DIV=13, PERIOD_MAX=254, duty 0x80 -> high 128 of 255 ticks.
- All 16 PWM pins share the same phase: identical edges on the same clk.
- No internal state depends on enable inputs; disabling then re-enabling a pin resumes at the current phase.

Optional Feature:
- Macro: PWM_PERIOD_PULSE_EN.
- Defined:
  - Port period_tick exists, registered.
  - period_tick=1 for exactly one clk, on the clk following each wrap tick (aligned with pwm_count becoming 0).
  - Reset value 0.
- Undefined:
  - Port and logic absent.
  - All other behaviour identical.

Test Plan:
- Reset: rst=1 for 3 clks with all inputs 0xFF -> out_pins=0x0000 during and on first clk after reset; pwm_count=0.
- Static enable: en_out=0xA5C3, en_pwm=0x0000 -> out_pins=0xA5C3 exactly one clk after the write; en_out=0x0000 -> 0x0000 one clk later.
- Duty extremes, en_out=en_pwm=0xFFFF:
  - duty 0x00 -> constant 0x0000 over 2 full periods.
  - duty 0xFF -> constant 0xFFFF over 2 full periods.
- Duty accuracy: CLK_DIV=4, duty 0x40 -> each pin high for 64×4=256 clks of every 255×4=1020 clks; all 16 pins toggle on the same clk.
- Shadow update: duty 0x20, write 0xC0 at pwm_count=100 -> current period high exactly 32 ticks; next period high 192 ticks.
- Optional pulse (PWM_PERIOD_PULSE_EN): CLK_DIV=2 -> period_tick pulses once every 510 clks, width 1 clk; no pulse during reset; rst asserted mid-period restarts spacing from reset release.
